// File: rtl/instr_ram_harvard_sync.sv
`default_nettype none
// ============================================================================
// instr_ram_harvard_sync: synchronous-read instruction RAM for the fetch path.
// Optional feature macro: INSTR_RAM_PARITY_EN (per-word even parity check).
// Revision 1.0
// ============================================================================
module instr_ram_harvard_sync #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] FAULT_WORD = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  input  logic                  fetch_hold,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_fault,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  localparam int                    BYTES    = DATA_WIDTH / 8;
  localparam int                    OFF_W    = $clog2(BYTES);
  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);

  if ((DATA_WIDTH % 8) != 0 || BYTES != (1 << OFF_W)) begin : g_bad_data_width
    $error("instr_ram_harvard_sync: DATA_WIDTH must be a power-of-two number of bytes");
  end
  if (DEPTH < 2 || DEPTH != (1 << IDX_W)) begin : g_bad_depth
    $error("instr_ram_harvard_sync: DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  fault_q;

  // Array is zero at time zero and deliberately untouched by rst_n.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [ADDR_WIDTH-1:0] fetch_word;
  logic [IDX_W-1:0]      fetch_idx;
  logic                  fetch_bad;
  logic [ADDR_WIDTH-1:0] load_word;
  logic [IDX_W-1:0]      load_idx;
  logic                  load_ok;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_par_err;

  assign fetch_word = fetch_addr >> OFF_W;
  assign fetch_idx  = fetch_word[IDX_W-1:0];
  assign fetch_bad  = ((fetch_addr & OFF_MASK) != '0) || ((fetch_word >> IDX_W) != '0);

  assign load_word  = load_addr >> OFF_W;
  assign load_idx   = load_word[IDX_W-1:0];
  assign load_ok    = load_en && ((load_addr & OFF_MASK) == '0) && ((load_word >> IDX_W) == '0);

  // Load owns the array for the cycle, so read-during-write never arises.
  assign fetch_ready = !load_en && ((state == EMPTY) || !fetch_hold);
  assign accept      = fetch_req && fetch_ready;

  assign rd_word = mem[fetch_idx];

  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_idx] <= load_data;
    end
  end

`ifdef INSTR_RAM_PARITY_EN
  logic par_mem [DEPTH] = '{default: 1'b0};

  always_ff @(posedge clk) begin
    if (load_ok) begin
      par_mem[load_idx] <= ^load_data;
    end
  end

  assign rd_par_err = (^rd_word) != par_mem[fetch_idx];
`else
  assign rd_par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state   <= FULL;
            data_q  <= fetch_bad ? FAULT_WORD : rd_word;
            fault_q <= fetch_bad || rd_par_err;
          end
        end
        FULL: begin
          // A held response is frozen; fetch_ready is low so no accept can occur.
          if (accept) begin
            data_q  <= fetch_bad ? FAULT_WORD : rd_word;
            fault_q <= fetch_bad || rd_par_err;
          end else if (!fetch_hold) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign fetch_valid = (state == FULL);
  assign fetch_data  = data_q;
  assign fetch_fault = fault_q;

endmodule
`default_nettype wire
